// File: rtl/div_arbiter_if.sv
// Requester-side bundle of the divider arbiter: request levels, packed operands,
// grant and response pulses, shared response data and the busy flag.
interface div_arbiter_if #(
    parameter int WIDTH = 512,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_q;
    logic [WIDTH-1:0]      rsp_r;
    logic                  rsp_err;
    logic                  busy;

    modport slave (
        input  req, req_dividend, req_divisor,
        output gnt, rsp_valid, rsp_q, rsp_r, rsp_err, busy
    );

    modport master (
        output req, req_dividend, req_divisor,
        input  gnt, rsp_valid, rsp_q, rsp_r, rsp_err, busy
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one wide divider among NREQ requesters, with
// local divide-by-zero handling, a stale-done guard and a completion timeout.
module div_arbiter #(
    parameter int WIDTH   = 512,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1100
) (
    input  logic             clk,
    input  logic             rst_n,
    div_arbiter_if.slave     bus,
    output logic             div_start,
    output logic [WIDTH-1:0] div_q,
    output logic [WIDTH-1:0] div_m,
    output logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_qout,
    input  logic [WIDTH-1:0] div_rem,
    input  logic             div_done
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t           state_reg, state_next;
    logic [IW-1:0]    ptr_reg, ptr_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [WIDTH-1:0] rq_reg, rq_next;
    logic [WIDTH-1:0] rr_reg, rr_next;
    logic             err_reg, err_next;

    logic [NREQ-1:0]  gnt_w;
    logic [NREQ-1:0]  rsp_valid_w;
    logic             start_w;

    logic [WIDTH-1:0] dividend_arr [NREQ];
    logic [WIDTH-1:0] divisor_arr  [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign dividend_arr[gi] = bus.req_dividend[gi*WIDTH +: WIDTH];
            assign divisor_arr[gi]  = bus.req_divisor[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan downwards so the candidate closest to ptr is the one left standing.
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [IW:0]   cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (bus.req[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            rq_reg    <= '0;
            rr_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            m_reg     <= m_next;
            rq_reg    <= rq_next;
            rr_reg    <= rr_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        q_next      = q_reg;
        m_next      = m_reg;
        rq_next     = rq_reg;
        rr_next     = rr_reg;
        err_next    = err_reg;
        gnt_w       = '0;
        rsp_valid_w = '0;
        start_w     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rst_n && sel_found) begin
                    gnt_w[sel_idx] = 1'b1;
                    idx_next       = sel_idx;
                    q_next         = dividend_arr[sel_idx];
                    m_next         = divisor_arr[sel_idx];
                    if (divisor_arr[sel_idx] == '0) begin
                        rq_next    = '1;
                        rr_next    = dividend_arr[sel_idx];
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                start_w    = rst_n;
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                cnt_next = cnt_reg + CW'(1);
                // A done seen on the first WAIT cycle may belong to the previous job.
                if (cnt_reg != '0 && div_done) begin
                    rq_next    = div_qout;
                    rr_next    = div_rem;
                    err_next   = 1'b0;
                    state_next = RESP;
                end else if (cnt_reg == CW'(TIMEOUT - 2)) begin
                    rq_next    = '0;
                    rr_next    = '0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rst_n)
                    rsp_valid_w[idx_reg] = 1'b1;
                ptr_next   = (idx_reg == IW'(NREQ - 1)) ? '0 : idx_reg + IW'(1);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.gnt       = gnt_w;
    assign bus.rsp_valid = rsp_valid_w;
    assign bus.rsp_q     = rq_reg;
    assign bus.rsp_r     = rr_reg;
    assign bus.rsp_err   = err_reg;
    assign bus.busy      = (state_reg != IDLE);

    assign div_start = start_w;
    assign div_q     = q_reg;
    assign div_m     = m_reg;
    assign div_a     = '0;
endmodule
